// File: rtl/simon_seq_ctrl_if.sv
// simon_seq_ctrl_if: host-side request (start/key/plaintext) and response (busy/done/ciphertext) bundle
interface simon_seq_ctrl_if;
   logic        i_start;
   logic [63:0] i_key;
   logic [31:0] i_pt;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_ct;
   modport master (output i_start, i_key, i_pt, input o_busy, o_done, o_ct);
   modport slave  (input i_start, i_key, i_pt, output o_busy, o_done, o_ct);
endinterface

// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl: loads key/plaintext nibble-serially into a Simon32/64 core, times ROUNDS rounds and
// unloads the ciphertext. Optional SIMON_SEQ_STREAM_EN: accept the next block at the last round cycle
// and capture the previous ciphertext while the new block is being shifted in.
module simon_seq_ctrl #(
   parameter int ROUNDS = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   simon_seq_ctrl_if.slave   host,
   output logic              o_core_shift,
   output logic [3:0]        o_core_data,
   input  logic [3:0]        i_core_data
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_UNLOAD} state_t;
   localparam logic [4:0] RUN_LAST = 5'(ROUNDS - 1);
   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [95:0] r_sr;
   logic [31:0] r_ct_sr;
   logic [31:0] r_ct;
   logic        r_busy;
   logic        r_done;
   logic        r_shift;
   logic [3:0]  r_data;
   logic [31:0] w_ct_next;
`ifdef SIMON_SEQ_STREAM_EN
   logic        r_pend;
`endif
   assign w_ct_next    = {i_core_data, r_ct_sr[31:4]};
   assign host.o_busy  = r_busy;
   assign host.o_done  = r_done;
   assign host.o_ct    = r_ct;
   assign o_core_shift = r_shift;
   assign o_core_data  = r_data;
   // Sequencer FSM: IDLE -> LOAD (24 nibbles in) -> RUN (ROUNDS cycles) -> UNLOAD (8 nibbles out)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_sr    <= '0;
         r_ct_sr <= '0;
         r_ct    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_shift <= 1'b0;
         r_data  <= '0;
`ifdef SIMON_SEQ_STREAM_EN
         r_pend  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (host.i_start) begin
                  r_state <= S_LOAD;
                  r_cnt   <= 5'd23;
                  r_sr    <= {4'h0, host.i_key, host.i_pt[31:4]};
                  r_data  <= host.i_pt[3:0];
                  r_shift <= 1'b1;
                  r_busy  <= 1'b1;
`ifdef SIMON_SEQ_STREAM_EN
                  r_pend  <= 1'b0;
`endif
               end
            end
            S_LOAD: begin
`ifdef SIMON_SEQ_STREAM_EN
               // while the new block enters, the core shifts out the previous block's ciphertext
               if (r_pend && r_cnt >= 5'd16) begin
                  r_ct_sr <= w_ct_next;
                  if (r_cnt == 5'd16) begin
                     r_ct   <= w_ct_next;
                     r_done <= 1'b1;
                  end
               end
`endif
               if (r_cnt == 5'd0) begin
                  r_state <= S_RUN;
                  r_cnt   <= RUN_LAST;
                  r_shift <= 1'b0;
                  r_data  <= '0;
               end else begin
                  r_cnt  <= r_cnt - 5'd1;
                  r_data <= r_sr[3:0];
                  r_sr   <= {4'h0, r_sr[95:4]};
               end
            end
            S_RUN: begin
               if (r_cnt == 5'd0) begin
`ifdef SIMON_SEQ_STREAM_EN
                  if (host.i_start) begin
                     r_state <= S_LOAD;
                     r_cnt   <= 5'd23;
                     r_sr    <= {4'h0, host.i_key, host.i_pt[31:4]};
                     r_data  <= host.i_pt[3:0];
                     r_shift <= 1'b1;
                     r_pend  <= 1'b1;
                  end else
`endif
                  begin
                     r_state <= S_UNLOAD;
                     r_cnt   <= 5'd7;
                     r_shift <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            S_UNLOAD: begin
               r_ct_sr <= w_ct_next;
               if (r_cnt == 5'd0) begin
                  r_state <= S_IDLE;
                  r_ct    <= w_ct_next;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_shift <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_simon_seq_ctrl.sv
// tb_simon_seq_ctrl: controller driving a behavioural nibble-serial Simon32/64 core, scoreboard-checked
module tb_simon_seq_ctrl;
   localparam logic [63:0] KEY = 64'h1918111009080100;
   localparam logic [31:0] PT  = 32'h65656877;
   localparam logic [31:0] CT  = 32'hc69be9bb;
`ifdef SIMON_SEQ_STREAM_EN
   localparam int PERIOD = 56;
`else
   localparam int PERIOD = 65;
`endif
   typedef struct {
      logic [31:0] ct;
      int          cyc;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_shift;
   logic [3:0]  core_di;
   logic [3:0]  core_do;
   logic [95:0] core_reg = '0;
   int          core_i = 0;
   logic [61:0] z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        sb[$];
   logic [3:0]  exp_nib [24] = '{4'h7, 4'h7, 4'h8, 4'h6, 4'h5, 4'h6, 4'h5, 4'h6,
                                 4'h0, 4'h0, 4'h1, 4'h0, 4'h8, 4'h0, 4'h9, 4'h0,
                                 4'h0, 4'h1, 4'h1, 4'h1, 4'h8, 4'h1, 4'h9, 4'h1};
   simon_seq_ctrl_if bus ();
   simon_seq_ctrl #(.ROUNDS(32)) dut (
      .i_clk(clk), .i_rst(rst), .host(bus),
      .o_core_shift(core_shift), .o_core_data(core_di), .i_core_data(core_do)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [15:0] rol(input logic [15:0] v, input int s);
      return (v << s) | (v >> (16 - s));
   endfunction
   // one Simon32/64 round plus one key-schedule step; z0 bit i is the i-th character of the sequence
   function automatic logic [95:0] simon_round(input logic [95:0] r, input int i);
      logic [15:0] x, y, k0, k1, k3, t, kn;
      x  = r[31:16];
      y  = r[15:0];
      k0 = r[47:32];
      k1 = r[63:48];
      k3 = r[95:80];
      t  = rol(k3, 13) ^ k1;
      t  = t ^ rol(t, 15);
      kn = 16'hfffc ^ {15'b0, z0[61 - (i % 62)]} ^ k0 ^ t;
      return {kn, r[95:80], r[79:64], r[63:48], y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k0, x};
   endfunction
   assign core_do = core_reg[3:0];
   // behavioural core: shift moves nibbles through {key,round}, otherwise one round per cycle
   always @(posedge clk) begin
      if (core_shift) begin
         core_reg <= {core_di, core_reg[95:4]};
         core_i   <= 0;
      end else begin
         core_reg <= simon_round(core_reg, core_i);
         core_i   <= core_i + 1;
      end
   end
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // monitor: every o_done pops the oldest expectation and checks value and arrival cycle
   always @(negedge clk) begin
      if (bus.o_done) begin
         if (sb.size() == 0) check("unexpected_done", 64'(bus.o_done), 64'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            check("ct", 64'(bus.o_ct), 64'(e.ct));
            check("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end
   // issue one start (now=1: drive immediately, else at next negedge); a = edge count at acceptance
   task automatic launch(input bit now, input bit push, output int a);
      if (!now) @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_key   = KEY;
      bus.i_pt    = PT;
      @(posedge clk);
      #1;
      a = cyc;
      if (push) sb.push_back('{CT, a + 64});
      bus.i_start = 1'b0;
   endtask
   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask
   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.o_done && n < 300);
      check("done_seen", 64'(bus.o_done), 64'd1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end
   initial begin
      int a, bad;
      logic       sh [66];
      logic [3:0] dt [66];
      bus.i_start = 1'b0;
      bus.i_key   = '0;
      bus.i_pt    = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy",  64'(bus.o_busy), 64'd0);
      check("rst_done",  64'(bus.o_done), 64'd0);
      check("rst_ct",    64'(bus.o_ct), 64'd0);
      check("rst_shift", 64'(core_shift), 64'd0);
      check("rst_data",  64'(core_di), 64'd0);
      // hold-off: nothing happens without a start
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (core_shift || bus.o_busy || bus.o_done) bad++;
      end
      check("holdoff_quiet", 64'(bad), 64'd0);
      // KAT with load-order and shift-pattern trace
      launch(0, 1, a);
      for (int k = 1; k <= 65; k++) begin
         @(negedge clk);
         sh[k] = core_shift;
         dt[k] = core_di;
      end
      for (int k = 1; k <= 24; k++) check($sformatf("load_nib%0d", k), 64'(dt[k]), 64'(exp_nib[k-1]));
      bad = 0;
      for (int k = 1; k <= 24; k++) if (!sh[k]) bad++;
      check("shift_load", 64'(bad), 64'd0);
      bad = 0;
      for (int k = 25; k <= 56; k++) if (sh[k] || dt[k] != 4'h0) bad++;
      check("shift_run", 64'(bad), 64'd0);
      bad = 0;
      for (int k = 57; k <= 64; k++) if (!sh[k] || dt[k] != 4'h0) bad++;
      check("shift_unload", 64'(bad), 64'd0);
      check("shift_after", 64'(sh[65]), 64'd0);
      // busy/ignore: stray starts carrying other data, then a start in the done cycle
      repeat (3) @(negedge clk);
      launch(0, 1, a);
      wait_until(a + 9);
      bus.i_start = 1'b1;
      bus.i_key   = ~KEY;
      bus.i_pt    = ~PT;
      check("busy_c10", 64'(bus.o_busy), 64'd1);
      wait_until(a + 10);
      bus.i_start = 1'b0;
      wait_until(a + 39);
      bus.i_start = 1'b1;
      check("busy_c40", 64'(bus.o_busy), 64'd1);
      wait_until(a + 40);
      bus.i_start = 1'b0;
      wait_done();
      launch(1, 1, a);
      wait_done();
      // reset during RUN aborts the block
      repeat (3) @(negedge clk);
      launch(0, 0, a);
      wait_until(a + 29);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy",  64'(bus.o_busy), 64'd0);
      check("abort_ct",    64'(bus.o_ct), 64'd0);
      check("abort_done",  64'(bus.o_done), 64'd0);
      check("abort_shift", 64'(core_shift), 64'd0);
      repeat (3) @(negedge clk);
      launch(0, 1, a);
      wait_done();
      // start held high: back-to-back blocks
      repeat (3) @(negedge clk);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_key   = KEY;
      bus.i_pt    = PT;
      @(posedge clk);
      #1;
      a = cyc;
      for (int k = 0; k < 3; k++) sb.push_back('{CT, a + 64 + PERIOD * k});
`ifdef SIMON_SEQ_STREAM_EN
      sb.push_back('{CT, a + 64 + PERIOD * 3});
`endif
      repeat (3) wait_done();
      bus.i_start = 1'b0;
`ifdef SIMON_SEQ_STREAM_EN
      wait_done();
`endif
      repeat (80) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
